dtree_seq_ctrl: RTL

Sequential decision-tree evaluator and controller. It walks a runtime-loadable node table using one shared comparator, one node per clock. It replaces the fully unrolled combinational classifier when area matters more than latency. Samples enter and classes leave over valid/ready handshakes. The node table is written through a simple configuration port.

---
 rtl/dtree_seq_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/dtree_seq_ctrl.sv
// Sequential decision-tree evaluator: one shared comparator walks a
// runtime-loadable node table, one node per clock, behind valid/ready handshakes.
module dtree_seq_ctrl #(
    parameter int NUM_FEAT = 4,
    parameter int FW       = 8,
    parameter int CW       = 4,
    parameter int NODE_AW  = 5,
    localparam int FIDX_W  = $clog2(NUM_FEAT),
    localparam int NODE_W  = 1 + FIDX_W + FW + 2*NODE_AW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_FEAT*FW-1:0] in_feat,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CW-1:0]          out_class,
    output logic                   out_err,
    output logic                   busy,
    input  logic                   cfg_we,
    input  logic [NODE_AW-1:0]     cfg_addr,
    input  logic [NODE_W-1:0]      cfg_data,
    output logic                   cfg_err
);

    localparam int DEPTH = 2**NODE_AW;

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t                   state, state_nxt;
    logic [NODE_W-1:0]        node_mem [DEPTH];
    logic [NUM_FEAT*FW-1:0]   feat_q;
    logic [NODE_AW-1:0]       ptr;
    logic [NODE_AW-1:0]       step;
    logic                     armed;

    logic [NODE_W-1:0]        node_w;
    logic                     node_leaf;
    logic [FIDX_W-1:0]        node_fidx;
    logic [FW-1:0]            node_thr;
    logic [NODE_AW-1:0]       node_left;
    logic [NODE_AW-1:0]       node_right;
    logic [FW-1:0]            feat_sel;
    logic                     timeout;
    logic                     accept;

    assign node_w     = node_mem[ptr];
    assign node_leaf  = node_w[NODE_W-1];
    assign node_fidx  = node_w[NODE_W-2 -: FIDX_W];
    assign node_thr   = node_w[2*NODE_AW +: FW];
    assign node_left  = node_w[NODE_AW +: NODE_AW];
    assign node_right = node_w[0 +: NODE_AW];
    assign timeout    = (step == {NODE_AW{1'b1}});

    assign in_ready  = rst_n && (state == IDLE) && !cfg_we;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    // Feature index beyond NUM_FEAT (non power-of-two counts) compares against zero.
    always_comb begin
        feat_sel = '0;
        for (int i = 0; i < NUM_FEAT; i++) begin
            if (node_fidx == FIDX_W'(i)) begin
                feat_sel = feat_q[i*FW +: FW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = WALK;
            WALK: if (armed && (node_leaf || timeout)) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The first WALK cycle only lets the captured features settle; the root
    // is compared in the following cycle, one node per clock after that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feat_q    <= '0;
            ptr       <= '0;
            step      <= '0;
            armed     <= 1'b0;
            out_class <= '0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        feat_q <= in_feat;
                        ptr    <= '0;
                        step   <= '0;
                        armed  <= 1'b0;
                    end
                end
                WALK: begin
                    if (!armed) begin
                        armed <= 1'b1;
                    end else if (node_leaf) begin
                        out_class <= node_thr[CW-1:0];
                        out_err   <= 1'b0;
                    end else if (timeout) begin
                        out_class <= '0;
                        out_err   <= 1'b1;
                    end else begin
                        ptr  <= (feat_sel <= node_thr) ? node_left : node_right;
                        step <= step + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table writes land only while idle; anything else is dropped and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                node_mem[i] <= '0;
            end
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && (state != IDLE);
            if (cfg_we && (state == IDLE)) begin
                node_mem[cfg_addr] <= cfg_data;
            end
        end
    end

endmodule
